// File: rtl/gray_rx_decoder.sv
// gray_rx_decoder
//   Receives a gray-coded count (possibly asynchronous to i_clk), synchronizes
//   it, decodes it to binary and tracks it, flagging legal +1 steps and any
//   other change.
//
// Ports
//   i_clk      : sole clock, rising edge
//   rst_n      : asynchronous active-low reset (release must be synchronous
//                to i_clk; no release synchronizer is added here)
//   gray_in    : gray-coded count input [WIDTH-1:0]
//   clr_err    : synchronous clear of err_cnt, wins over a coincident error
//   bin_out    : registered binary value of the tracked count [WIDTH-1:0]
//   bin_valid  : high once bin_out holds a decoded sample
//   inc_pulse  : one-cycle pulse per legal +1 step (wrap included)
//   step_err   : one-cycle pulse per illegal step
//   err_cnt    : saturating count of illegal steps [7:0]
module gray_rx_decoder #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             inc_pulse,
  output logic             step_err,
  output logic [7:0]       err_cnt
);

  localparam int unsigned WCW = (SYNC_STAGES > 1) ? $clog2(SYNC_STAGES) : 1;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_LOCK  = 2'd1,
    ST_TRACK = 2'd2
  } state_e;

  state_e                              state_q, state_d;
  logic [WCW-1:0]                      wait_q, wait_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0]   sync_q;
  logic [WIDTH-1:0]                    bin_q, bin_d;
  logic                                valid_q, valid_d;
  logic                                inc_q, inc_d;
  logic                                err_q, err_d;
  logic [7:0]                          cnt_q, cnt_d;
  logic [WIDTH-1:0]                    dec;

  // Binary bit k is the XOR of all gray bits at or above k.
  always_comb begin
    dec = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      dec[k] = ^(sync_q[SYNC_STAGES-1] >> k);
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    bin_d   = bin_q;
    valid_d = valid_q;
    inc_d   = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      // Let the freshly reset sync chain fill before trusting its output.
      ST_WAIT: begin
        if (wait_q == WCW'(SYNC_STAGES - 1)) begin
          state_d = ST_LOCK;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_LOCK: begin
        bin_d   = dec;
        valid_d = 1'b1;
        state_d = ST_TRACK;
      end
      ST_TRACK: begin
        if (dec == bin_q) begin
          bin_d = bin_q;
        end else if (dec == bin_q + WIDTH'(1)) begin
          // Modular add makes the all-ones -> zero wrap a legal step.
          bin_d = dec;
          inc_d = 1'b1;
        end else begin
          bin_d = dec;
          err_d = 1'b1;
          if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = ST_WAIT;
    endcase
    if (clr_err) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= ST_WAIT;
      wait_q  <= '0;
      bin_q   <= '0;
      valid_q <= 1'b0;
      inc_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q[0] <= gray_in;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      state_q <= state_d;
      wait_q  <= wait_d;
      bin_q   <= bin_d;
      valid_q <= valid_d;
      inc_q   <= inc_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bin_out   = bin_q;
  assign bin_valid = valid_q;
  assign inc_pulse = inc_q;
  assign step_err  = err_q;
  assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_gray_rx_decoder.sv
// tb_gray_rx_decoder
//   Self-checking bench for gray_rx_decoder (WIDTH=4, SYNC_STAGES=2).
//   The reference model treats the synchronizer as a pure S-edge delay,
//   decodes gray by table lookup and judges steps with modular arithmetic.
module tb_gray_rx_decoder;

  localparam int unsigned S = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] gray_in;
  logic       clr_err;
  logic [3:0] bin_out;
  logic       bin_valid;
  logic       inc_pulse;
  logic       step_err;
  logic [7:0] err_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  gray_rx_decoder #(.WIDTH(4), .SYNC_STAGES(S)) dut (
    .i_clk    (clk),
    .rst_n    (rst_n),
    .gray_in  (gray_in),
    .clr_err  (clr_err),
    .bin_out  (bin_out),
    .bin_valid(bin_valid),
    .inc_pulse(inc_pulse),
    .step_err (step_err),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [3:0]  m_pipe[$];
  int unsigned m_cyc;
  logic [3:0]  m_bin;
  logic        m_valid, m_inc, m_err;
  int unsigned m_cnt;

  logic [14:0] obs;
  assign obs = {bin_out, bin_valid, inc_pulse, step_err, err_cnt};

  function automatic logic [3:0] gray_of(int unsigned v);
    return 4'(v ^ (v >> 1));
  endfunction

  function automatic logic [3:0] bin_of(logic [3:0] g);
    for (int unsigned v = 0; v < 16; v++) begin
      if (gray_of(v) == g) return 4'(v);
    end
    return 4'd0;
  endfunction

  function automatic logic [14:0] exp_vec();
    return {m_bin, m_valid, m_inc, m_err, 8'(m_cnt)};
  endfunction

  task automatic model_reset();
    m_pipe = {};
    for (int unsigned i = 0; i < S; i++) m_pipe.push_back(4'd0);
    m_cyc = 0; m_bin = 4'd0; m_valid = 1'b0;
    m_inc = 1'b0; m_err = 1'b0; m_cnt = 0;
  endtask

  task automatic model_edge();
    logic [3:0]  seen;
    int unsigned d;
    if (!rst_n) begin
      model_reset();
      return;
    end
    seen = m_pipe.pop_front();
    m_pipe.push_back(gray_in);
    m_inc = 1'b0;
    m_err = 1'b0;
    m_cyc++;
    if (m_cyc == S + 1) begin
      m_bin   = bin_of(seen);
      m_valid = 1'b1;
    end else if (m_cyc > S + 1) begin
      d = int'(bin_of(seen));
      if (d == int'(m_bin)) begin
        m_inc = 1'b0;
      end else if (d == (int'(m_bin) + 1) % 16) begin
        m_inc = 1'b1;
        m_bin = 4'(d);
      end else begin
        m_err = 1'b1;
        m_bin = 4'(d);
      end
    end
    if (clr_err) m_cnt = 0;
    else if (m_err && m_cnt < 255) m_cnt++;
  endtask

  // Advance one clock: model follows the rising edge, bench resumes at the
  // falling edge where outputs are sampled and inputs are changed.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [3:0] g);
    rst_n   = 1'b0;
    gray_in = g;
    clr_err = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (S + 1) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n   = 1'b0;
    gray_in = 4'b0110;
    clr_err = 1'b0;
    model_reset();
    #1;
    total++;
    if (obs !== 15'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=%h", obs, 15'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned i = 0; i < S; i++) begin
      tick();
      total++;
      if (bin_valid !== 1'b0 || obs !== exp_vec()) begin
        bad++; $display("FAIL wait_phase cyc=%0d got=%h want=%h", i, obs, exp_vec());
      end
    end
    tick();
    total++;
    if (bin_out !== 4'b0100 || bin_valid !== 1'b1 || inc_pulse !== 1'b0 || step_err !== 1'b0) begin
      bad++; $display("FAIL lock_value got bin=%b v=%b i=%b e=%b want bin=0100 v=1 i=0 e=0",
                      bin_out, bin_valid, inc_pulse, step_err);
    end
    total++;
    if (obs !== exp_vec()) begin
      bad++; $display("FAIL lock_model got=%h want=%h", obs, exp_vec());
    end
  endtask

  task automatic test_full_seq();
    int unsigned incs = 0;
    do_reset(4'b0000);
    for (int unsigned v = 1; v <= 16 + S; v++) begin
      if (v <= 16) gray_in = gray_of(v % 16);
      tick();
      if (inc_pulse === 1'b1) incs++;
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL full_seq step=%0d got=%h want=%h", v, obs, exp_vec());
      end
    end
    total++;
    if (incs != 16 || bin_out !== 4'd0 || err_cnt !== 8'd0) begin
      bad++; $display("FAIL full_seq_end got incs=%0d bin=%0d err=%0d want 16 0 0",
                      incs, bin_out, err_cnt);
    end
  endtask

  task automatic test_illegal();
    logic [3:0]  seq [3];
    int unsigned errs = 0;
    seq[0] = 4'b0101; seq[1] = 4'b0100; seq[2] = 4'b0010;
    do_reset(4'b0111);
    total++;
    if (bin_out !== 4'd5) begin
      bad++; $display("FAIL illegal_start got=%0d want=5", bin_out);
    end
    for (int unsigned i = 0; i < 3 + S; i++) begin
      if (i < 3) gray_in = seq[i];
      tick();
      if (step_err === 1'b1) begin
        errs++;
        total++;
        if (bin_out !== 4'd3) begin
          bad++; $display("FAIL illegal_resync got=%0d want=3", bin_out);
        end
      end
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL illegal_step i=%0d got=%h want=%h", i, obs, exp_vec());
      end
    end
    total++;
    if (errs != 1 || bin_out !== 4'd3 || err_cnt !== 8'd1) begin
      bad++; $display("FAIL illegal_end got errs=%0d bin=%0d cnt=%0d want 1 3 1", errs, bin_out, err_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset(4'b0000);
    for (int unsigned i = 0; i < 300; i++) begin
      gray_in = (i % 2 == 0) ? gray_of(5) : gray_of(0);
      tick();
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL sat_step i=%0d got=%h want=%h", i, obs, exp_vec());
      end
    end
    total++;
    if (err_cnt !== 8'd255) begin
      bad++; $display("FAIL sat_value got=%0d want=255", err_cnt);
    end
    gray_in = gray_of(5);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    total++;
    if (err_cnt !== 8'd0 || step_err !== 1'b1 || obs !== exp_vec()) begin
      bad++; $display("FAIL clr_priority got cnt=%0d err=%b want cnt=0 err=1", err_cnt, step_err);
    end
    gray_in = gray_of(0);
    tick();
    total++;
    if (err_cnt !== 8'd1 || obs !== exp_vec()) begin
      bad++; $display("FAIL after_clr got=%0d want=1", err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(gray_of(9));
    total++;
    if (bin_out !== 4'd9 || bin_valid !== 1'b1) begin
      bad++; $display("FAIL mid_pre got bin=%0d v=%b want 9 1", bin_out, bin_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 15'd0) begin
      bad++; $display("FAIL mid_async got=%h want=%h", obs, 15'd0);
    end
    model_reset();
    gray_in = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned i = 0; i < S + 1; i++) begin
      tick();
      total++;
      if (step_err !== 1'b0 || obs !== exp_vec()) begin
        bad++; $display("FAIL mid_relock i=%0d got=%h want=%h", i, obs, exp_vec());
      end
    end
    total++;
    if (bin_out !== 4'd0 || bin_valid !== 1'b1) begin
      bad++; $display("FAIL mid_final got bin=%0d v=%b want 0 1", bin_out, bin_valid);
    end
  endtask

  task automatic test_stall();
    do_reset(gray_of(11));
    for (int unsigned i = 0; i < 50; i++) begin
      tick();
      total++;
      if (inc_pulse !== 1'b0 || step_err !== 1'b0 || bin_out !== 4'd11) begin
        bad++; $display("FAIL stall i=%0d got bin=%0d i=%b e=%b want 11 0 0",
                        i, bin_out, inc_pulse, step_err);
      end
    end
  endtask

  task automatic test_random();
    int unsigned cur = 0;
    int unsigned r;
    do_reset(4'b0000);
    for (int unsigned i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      cur = (cur + 1) % 16;
      else if (r < 8) cur = cur;
      else            cur = $urandom_range(0, 15);
      gray_in = gray_of(cur);
      clr_err = ($urandom_range(0, 19) == 0);
      tick();
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL random i=%0d got=%h want=%h", i, obs, exp_vec());
      end
    end
    clr_err = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_seq();
    test_illegal();
    test_saturation();
    test_reset_mid();
    test_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
